// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Purpose:
//   Shares one asynchronous 16-bit SRAM between two requesters. Port 0 is the
//   CPU memory path (MAR/MDR) and port 1 is the debug/program loader. Each
//   granted access runs as a fixed multi-cycle read or write. The arbiter
//   drives the active-low SRAM strobes itself, so the instruction sequencer
//   no longer has direct control of them. Arbitration is round-robin, and each
//   port uses a req/ack handshake.
//
// Ports:
//   Clk, Reset          system clock (rising edge); synchronous active-high reset
//   Req0/We0/Addr0/WData0
//                       port 0 request (held until Ack0), write flag, address,
//                       write data
//   Ack0, RData0        port 0 one-cycle completion pulse; read data, which is
//                       valid from Ack0 until the next port 0 read completes
//   Req1/We1/Addr1/WData1/Ack1/RData1
//                       same set of signals for port 1
//   Mem_ADDR            SRAM address, held from grant through RECOVER
//   Data_to_SRAM        write data to the external tristate buffer
//   Data_from_SRAM      data read back from the SRAM bus
//   Drive_En            1 = the tristate buffer drives Data_to_SRAM onto the bus
//   Mem_CE/UB/LB/OE/WE  active-low SRAM strobes
//
// Every output is a register, so no combinational path runs from a request
// input to a strobe.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W       = 20,
    parameter int DATA_W       = 16,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              Req0,
    input  logic              We0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Ack0,
    output logic [DATA_W-1:0] RData0,

    input  logic              Req1,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData1,

    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Drive_En,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
);

    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    // The counter starts at K-1 and reaches 0 in the last ACCESS cycle.
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                grant_q;       // port that owns the current access
    logic                last_grant_q;  // port granted most recently
    logic                we_q;          // current access is a write

    logic                ack0_q, ack1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                drive_en_q;
    logic                ce_n_q, oe_n_q, we_n_q;

    // Arbitration decode. These values feed only the state registers and are
    // used only in IDLE.
    logic                grant_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        grant_d = 1'b0;
        we_d    = We0;
        addr_d  = Addr0;
        wdata_d = WData0;

        // On a tie, the port that did not win last time gets the grant.
        // Otherwise the single requester wins, which is port 1 exactly when
        // Req1 is set.
        if (Req0 && Req1) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = Req1;
        end

        if (grant_d) begin
            we_d    = We1;
            addr_d  = Addr1;
            wdata_d = WData1;
        end
    end

    // NOTE: all sequential state is written with non-blocking assignments, so
    // every register samples pre-edge values and the update order does not
    // matter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;       // port 0 wins the first tie
            we_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            drive_en_q   <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
        end else begin
            // Acks are single-cycle pulses. They are set only on the edge
            // that enters RECOVER.
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (Req0 || Req1) begin
                        state_q      <= ACCESS;
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        we_q         <= we_d;
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        cnt_q        <= we_d ? WR_LOAD : RD_LOAD;
                        ce_n_q       <= 1'b0;
                        oe_n_q       <= we_d;
                        we_n_q       <= ~we_d;
                        drive_en_q   <= we_d;
                    end
                end

                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q <= RECOVER;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        // Drive_En stays high through RECOVER on a write. This
                        // holds the data on the bus after WE rises.
                        if (!we_q) begin
                            if (grant_q) rdata1_q <= Data_from_SRAM;
                            else         rdata0_q <= Data_from_SRAM;
                        end
                        if (grant_q) ack1_q <= 1'b1;
                        else         ack0_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                RECOVER: begin
                    state_q    <= IDLE;
                    drive_en_q <= 1'b0;
                end

                default: begin
                    state_q    <= IDLE;
                    ce_n_q     <= 1'b1;
                    oe_n_q     <= 1'b1;
                    we_n_q     <= 1'b1;
                    drive_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign Ack0         = ack0_q;
    assign Ack1         = ack1_q;
    assign RData0       = rdata0_q;
    assign RData1       = rdata1_q;
    assign Mem_ADDR     = addr_q;
    assign Data_to_SRAM = wdata_q;
    assign Drive_En     = drive_en_q;
    assign Mem_CE       = ce_n_q;
    assign Mem_UB       = ce_n_q;   // both byte lanes are always enabled together with CE
    assign Mem_LB       = ce_n_q;
    assign Mem_OE       = oe_n_q;
    assign Mem_WE       = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed testbench for sram_arbiter. A small behavioural SRAM answers reads
// while CE and OE are low. It stores write data on each clock edge where CE
// and WE are low and the buffer is driving. Every step advances one clock,
// then compares DUT outputs 1 ns after the rising edge against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;

    // Strobe patterns, packed as {CE, UB, LB, OE, WE, Drive_En}.
    localparam logic [5:0] S_IDLE = 6'b111110;
    localparam logic [5:0] S_RD   = 6'b000010;
    localparam logic [5:0] S_WR   = 6'b000101;
    localparam logic [5:0] S_RECW = 6'b111111;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Req0, We0, Req1, We1;
    logic [ADDR_W-1:0] Addr0, Addr1;
    logic [DATA_W-1:0] WData0, WData1;
    logic              Ack0, Ack1;
    logic [DATA_W-1:0] RData0, RData1;
    logic [ADDR_W-1:0] Mem_ADDR;
    logic [DATA_W-1:0] Data_to_SRAM, Data_from_SRAM;
    logic              Drive_En, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] mem [0:255];

    always #5 Clk = ~Clk;

    sram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .READ_CYCLES (2),
        .WRITE_CYCLES(2)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req0          (Req0),
        .We0           (We0),
        .Addr0         (Addr0),
        .WData0        (WData0),
        .Ack0          (Ack0),
        .RData0        (RData0),
        .Req1          (Req1),
        .We1           (We1),
        .Addr1         (Addr1),
        .WData1        (WData1),
        .Ack1          (Ack1),
        .RData1        (RData1),
        .Mem_ADDR      (Mem_ADDR),
        .Data_to_SRAM  (Data_to_SRAM),
        .Data_from_SRAM(Data_from_SRAM),
        .Drive_En      (Drive_En),
        .Mem_CE        (Mem_CE),
        .Mem_UB        (Mem_UB),
        .Mem_LB        (Mem_LB),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE)
    );

    // Behavioural asynchronous SRAM.
    assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? mem[Mem_ADDR[7:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (Reset) begin
            mem[8'h10] <= 16'h1234;
        end else if (!Mem_CE && !Mem_WE && Drive_En) begin
            mem[Mem_ADDR[7:0]] <= Data_to_SRAM;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strobes();
        return {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Drive_En};
    endfunction

    initial begin
        Reset = 1'b1;
        Req0 = 1'b0; We0 = 1'b0; Addr0 = '0; WData0 = '0;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; WData1 = '0;
        tick(); tick();
        Reset = 1'b0;

        // Reset state.
        check("rst_strobes", strobes(), S_IDLE);
        check("rst_acks",    {Ack1, Ack0}, 2'b00);
        check("rst_rdata0",  RData0, 16'h0000);
        check("rst_rdata1",  RData1, 16'h0000);
        check("rst_addr",    Mem_ADDR, 20'h00000);
        check("rst_wdata",   Data_to_SRAM, 16'h0000);

        // Port 0 read of 0x00010. The SRAM holds 0x1234 there.
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00010;
        tick();
        check("rd0_a1_strobes", strobes(), S_RD);
        check("rd0_a1_addr",    Mem_ADDR, 20'h00010);
        check("rd0_a1_ack",     Ack0, 1'b0);
        tick();
        check("rd0_a2_strobes", strobes(), S_RD);
        check("rd0_a2_ack",     Ack0, 1'b0);
        tick();
        check("rd0_rec_strobes", strobes(), S_IDLE);
        check("rd0_rec_ack0",    Ack0, 1'b1);
        check("rd0_rec_rdata0",  RData0, 16'h1234);
        Req0 = 1'b0;
        tick();
        check("rd0_idle_ack0",   Ack0, 1'b0);
        check("rd0_idle_rdata0", RData0, 16'h1234);

        // Port 1 write of 0xBEEF to 0x00020.
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 20'h00020; WData1 = 16'hBEEF;
        tick();
        check("wr1_a1_strobes", strobes(), S_WR);
        check("wr1_a1_addr",    Mem_ADDR, 20'h00020);
        check("wr1_a1_data",    Data_to_SRAM, 16'hBEEF);
        tick();
        check("wr1_a2_strobes", strobes(), S_WR);
        tick();
        check("wr1_rec_strobes", strobes(), S_RECW);
        check("wr1_rec_acks",    {Ack1, Ack0}, 2'b10);
        Req1 = 1'b0;
        tick();
        check("wr1_idle_strobes", strobes(), S_IDLE);
        check("wr1_idle_acks",    {Ack1, Ack0}, 2'b00);

        // Port 0 reads the location that port 1 just wrote.
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00020;
        tick(); tick(); tick();
        check("rdback_ack0",   Ack0, 1'b1);
        check("rdback_rdata0", RData0, 16'hBEEF);
        Req0 = 1'b0;
        tick();

        // Both ports request right after reset. Grants must go 0,1,0,1, with
        // Acks every 4 cycles and never together.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rst2_rdata0", RData0, 16'h0000);
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00010;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 20'h00020;
        for (int t = 1; t <= 16; t++) begin
            logic [1:0] exp_ack;
            tick();
            exp_ack = 2'b00;
            if (t % 4 == 3) exp_ack = ((t / 4) % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("rr_ack_t%0d", t), {Ack1, Ack0}, exp_ack);
            if (t == 3)  check("rr_rdata0", RData0, 16'h1234);
            if (t == 7)  check("rr_rdata1", RData1, 16'hBEEF);
            if (t == 5)  check("rr_addr_p1", Mem_ADDR, 20'h00020);
            if (t == 9)  check("rr_addr_p0", Mem_ADDR, 20'h00010);
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();
        check("rr_withdrawn_strobes", strobes(), S_IDLE);

        // Back-to-back writes from port 0. Addr0 and WData0 change during the
        // first access and must be ignored until the next grant.
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 20'h00030; WData0 = 16'h1111;
        tick();
        check("bb_a1_strobes", strobes(), S_WR);
        check("bb_a1_addr",    Mem_ADDR, 20'h00030);
        Addr0 = 20'h00040; WData0 = 16'h2222;
        tick();
        check("bb_a2_addr", Mem_ADDR, 20'h00030);
        check("bb_a2_data", Data_to_SRAM, 16'h1111);
        tick();
        check("bb_rec_strobes", strobes(), S_RECW);
        check("bb_rec_ack0",    Ack0, 1'b1);
        check("bb_rec_addr",    Mem_ADDR, 20'h00030);
        tick();
        check("bb_idle_strobes", strobes(), S_IDLE);
        tick();
        check("bb2_a1_strobes", strobes(), S_WR);
        check("bb2_a1_addr",    Mem_ADDR, 20'h00040);
        check("bb2_a1_data",    Data_to_SRAM, 16'h2222);
        Req0 = 1'b0;   // dropped after grant; the write still completes
        tick();
        tick();
        check("bb2_rec_ack0", Ack0, 1'b1);
        tick();
        check("bb2_idle_strobes", strobes(), S_IDLE);
        check("bb_mem30", mem[8'h30], 16'h1111);
        check("bb_mem40", mem[8'h40], 16'h2222);

        // Reset during the first ACCESS cycle of a read.
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00010;
        tick();
        check("rstacc_a1_strobes", strobes(), S_RD);
        Reset = 1'b1; Req0 = 1'b0;
        tick();
        Reset = 1'b0;
        check("rstacc_strobes", strobes(), S_IDLE);
        check("rstacc_ack0",    Ack0, 1'b0);
        check("rstacc_rdata0",  RData0, 16'h0000);
        tick();
        check("rstacc_ack0_b", Ack0, 1'b0);
        tick();
        check("rstacc_ack0_c",   Ack0, 1'b0);
        check("rstacc_strobes_c", strobes(), S_IDLE);

        // Port 1 raises and then withdraws its request while port 0 is busy.
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 20'h00010;
        tick();
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 20'h00050; WData1 = 16'h5555;
        tick();
        Req1 = 1'b0;
        tick();
        check("wd_rec_acks",   {Ack1, Ack0}, 2'b01);
        check("wd_rec_rdata0", RData0, 16'h1234);
        Req0 = 1'b0;
        tick();
        check("wd_idle_strobes", strobes(), S_IDLE);
        tick();
        check("wd_idle2_strobes", strobes(), S_IDLE);
        check("wd_idle2_ack1",    Ack1, 1'b0);
        tick();
        check("wd_idle3_strobes", strobes(), S_IDLE);
        check("wd_addr_kept",     Mem_ADDR, 20'h00010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single asynchronous 16-bit SRAM between two requesters: port 0 (CPU memory path, MAR/MDR) and port 1 (debug/program loader).
- Sequences every access as a fixed multi-cycle read or write and drives the active-low SRAM strobes, replacing direct strobe control from the instruction sequencer.
- Uses round-robin arbitration with a per-port req/ack handshake.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
READ_CYCLES, 2, cycles Mem_OE held low per read (>=1)
WRITE_CYCLES, 2, cycles Mem_WE held low per write (>=1)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
Req0  input  1  port 0 access request, held until Ack0
We0  input  1  port 0: 1=write, 0=read
Addr0  input  ADDR_W  port 0 address
WData0  input  DATA_W  port 0 write data
Ack0  output  1  one-cycle completion pulse, port 0
RData0  output  DATA_W  port 0 read data, valid from Ack0 until next port 0 read completes
Req1, We1, Addr1, WData1, Ack1, RData1  same as port 0, for port 1
Mem_ADDR  output  ADDR_W  SRAM address
Data_to_SRAM  output  DATA_W  write data to tristate buffer
Data_from_SRAM  input  DATA_W  data from SRAM bus
Drive_En  output  1  1 = tristate buffer drives Data_to_SRAM onto the bus
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  active-low SRAM strobes

Behaviour:
- States: IDLE, ACCESS, RECOVER.
- Reset values: state=IDLE, Ack0=Ack1=0, RData0=RData1=0, Mem_ADDR=0, Data_to_SRAM=0, Drive_En=0, all strobes=1, last_grant=1 (port 0 wins the first tie).
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port != last_grant.
  - On grant, on the same edge: register Mem_ADDR, Data_to_SRAM and the write flag from the winning port; update last_grant; load counter with (We ? WRITE_CYCLES : READ_CYCLES)-1; go to ACCESS.
- ACCESS:
  - Mem_CE=Mem_UB=Mem_LB=0.
  - Read: Mem_OE=0, Mem_WE=1, Drive_En=0.
  - Write: Mem_WE=0, Mem_OE=1, Drive_En=1.
  - Counter decrements each cycle. On the cycle the counter reads 0 (last access cycle): for a read, capture Data_from_SRAM into RData of the granted port at that edge; go to RECOVER.
- RECOVER:
  - Strobes all 1 and Mem_WE deasserted. Drive_En stays 1 for a write (data hold past WE rise).
  - Ack of the granted port = 1 for exactly this cycle, and RData is already valid.
  - Next state IDLE, unconditionally.
- Latency: Req sampled high in IDLE at cycle N -> ACCESS cycles N+1..N+K -> Ack at N+K+1, where K = READ_CYCLES or WRITE_CYCLES.
- Throughput: K+2 cycles per transaction.
- Requester rules:
  - Addr/We/WData must be stable from Req rise until Ack. They are sampled only at grant; later changes are ignored.
  - Req dropped before grant = request withdrawn, no access.
  - Req dropped after grant: the access still completes and Ack still pulses.
  - Req held high through Ack = new request, re-arbitrated in the following IDLE cycle.
- Fairness: with both ports requesting continuously, grants strictly alternate 0,1,0,1...
- Outputs are registered or decoded from state only. No combinational path from Req to any strobe.
- Reset mid-ACCESS or mid-RECOVER: next edge returns to IDLE with strobes=1 and Drive_En=0. The pending Ack is not issued. RData holds its reset value 0.
- Address and data are held constant for the whole ACCESS+RECOVER window. Mem_ADDR keeps its last value in IDLE.
- An Ack for one port never coincides with an Ack for the other.

Test Plan:
- Reset, then Req0=1, We0=0, Addr0=20'h00010, SRAM model holds x1234 -> Mem_OE low exactly 2 cycles, Ack0 pulses 3 cycles after grant, RData0=x1234, Mem_WE stays 1.
- Req1=1, We1=1, Addr1=20'h00020, WData1=xBEEF -> Mem_WE low 2 cycles, Drive_En high 3 cycles (ACCESS+RECOVER), Ack1 one pulse; a subsequent port 0 read of x00020 returns xBEEF.
- Req0 and Req1 both asserted together immediately after reset, held through 4 transactions -> grant order 0,1,0,1; Ack pulses spaced 4 cycles apart, never simultaneous.
- Back-to-back writes from port 0 only -> Mem_WE returns to 1 for at least 2 cycles (RECOVER+IDLE) between writes; Addr0 changed mid-ACCESS does not change Mem_ADDR.
- Reset asserted in the 1st ACCESS cycle of a read -> next cycle IDLE, all strobes 1, no Ack0, RData0=0.
- Req1 raised then dropped while a port 0 access is in progress -> port 1 never granted, no Ack1, no extra SRAM cycle.
